// File: rtl/pad_bank_inout.sv
// N-channel bidirectional pad bank: turnaround-sequenced drive enable, input synchroniser,
// debounce filter and edge pulses. Define PAD_BANK_LOOPBACK_EN to add per-channel loopback_i.
module pad_bank_inout #(
   parameter int unsigned NPADS       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 4,
   parameter int unsigned TURNAROUND  = 1,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NPADS-1:0] pad_out_i,
   input  logic [NPADS-1:0] pad_oe_i,
`ifdef PAD_BANK_LOOPBACK_EN
   input  logic [NPADS-1:0] loopback_i,
`endif
   inout  wire  [NPADS-1:0] pad_io,
   output logic [NPADS-1:0] pad_in_o,
   output logic [NPADS-1:0] pad_rise_o,
   output logic [NPADS-1:0] pad_fall_o,
   output logic [NPADS-1:0] pad_driving_o
);

   localparam int unsigned MAXV = (DEBOUNCE > TURNAROUND) ? DEBOUNCE : TURNAROUND;
   localparam int unsigned CW   = (MAXV < 1) ? 1 : $clog2(MAXV + 1);

   typedef enum logic [1:0] {IDLE, TURN, DRIVE} state_e;

   state_e                 state_q [NPADS];
   state_e                 state_d [NPADS];
   logic [CW-1:0]          tcnt_q  [NPADS];
   logic [CW-1:0]          tcnt_d  [NPADS];
   logic [CW-1:0]          dcnt_q  [NPADS];
   logic [CW-1:0]          dcnt_d  [NPADS];
   logic [SYNC_STAGES-1:0] sync_q  [NPADS];
   logic [SYNC_STAGES-1:0] sync_d  [NPADS];
   logic [NPADS-1:0]       in_q, in_d, prev_q, prev_d;
   logic [NPADS-1:0]       rise_q, rise_d, fall_q, fall_d;
   logic [NPADS-1:0]       drive, raw;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < NPADS; i++) begin
         drive[i] = (state_q[i] == DRIVE);
      end
   end

   // Only the enable is registered; the driven data follows pad_out_i combinationally.
   for (genvar g = 0; g < NPADS; g++) begin : g_pad
      assign pad_io[g] = drive[g] ? pad_out_i[g] : 1'bz;
   end

   always_comb begin
      for (int unsigned i = 0; i < NPADS; i++) begin
`ifdef PAD_BANK_LOOPBACK_EN
         raw[i] = loopback_i[i] ? (drive[i] ? pad_out_i[i] : RESET_VAL) : pad_io[i];
`else
         raw[i] = pad_io[i];
`endif
      end
   end

   always_comb begin
      in_d   = in_q;
      prev_d = in_q;
      rise_d = in_q & ~prev_q;
      fall_d = ~in_q & prev_q;
      for (int unsigned i = 0; i < NPADS; i++) begin
         state_d[i] = state_q[i];
         tcnt_d[i]  = tcnt_q[i];
         dcnt_d[i]  = dcnt_q[i];
         sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], raw[i]};

         unique case (state_q[i])
            IDLE: begin
               if (pad_oe_i[i]) begin
                  tcnt_d[i] = '0;
                  if (TURNAROUND > 0) state_d[i] = TURN;
                  else                state_d[i] = DRIVE;
               end
            end
            TURN: begin
               if (!pad_oe_i[i]) begin
                  state_d[i] = IDLE;
                  tcnt_d[i]  = '0;
               end else if (int'(tcnt_q[i]) >= int'(TURNAROUND) - 1) begin
                  state_d[i] = DRIVE;
                  tcnt_d[i]  = '0;
               end else begin
                  tcnt_d[i] = sat_inc(tcnt_q[i]);
               end
            end
            DRIVE: begin
               if (!pad_oe_i[i]) state_d[i] = IDLE;
            end
            default: state_d[i] = IDLE;
         endcase

         // Filtered value only moves after DEBOUNCE consecutive differing samples.
         if (DEBOUNCE == 0) begin
            in_d[i]   = sync_q[i][SYNC_STAGES-1];
            dcnt_d[i] = '0;
         end else if (sync_q[i][SYNC_STAGES-1] == in_q[i]) begin
            dcnt_d[i] = '0;
         end else if (int'(dcnt_q[i]) >= int'(DEBOUNCE) - 1) begin
            in_d[i]   = sync_q[i][SYNC_STAGES-1];
            dcnt_d[i] = '0;
         end else begin
            dcnt_d[i] = sat_inc(dcnt_q[i]);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NPADS; i++) begin
            state_q[i] <= IDLE;
            tcnt_q[i]  <= '0;
            dcnt_q[i]  <= '0;
            sync_q[i]  <= {SYNC_STAGES{RESET_VAL}};
         end
         in_q   <= {NPADS{RESET_VAL}};
         prev_q <= {NPADS{RESET_VAL}};
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NPADS; i++) begin
            state_q[i] <= state_d[i];
            tcnt_q[i]  <= tcnt_d[i];
            dcnt_q[i]  <= dcnt_d[i];
            sync_q[i]  <= sync_d[i];
         end
         in_q   <= in_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign pad_in_o      = in_q;
   assign pad_rise_o    = rise_q;
   assign pad_fall_o    = fall_q;
   assign pad_driving_o = drive;

endmodule

// File: doc/pad_bank_inout.md
Name: pad_bank_inout

Overview:
Parametrised N-channel bidirectional pad bank; successor to the single-channel pass-through inout pad cell. Per channel it adds:
- output-enable turnaround sequencing, which avoids bus contention;
- a multi-stage input synchroniser;
- a stable-count debounce filter;
- one-cycle edge pulses.
Sits between the X-HEEP pad ring and the pad control / GPIO logic. One instance replaces NPADS plain inout cells.

Parameters:
NPADS, 8, number of independent pad channels (>=1)
SYNC_STAGES, 2, input synchroniser flops per channel (>=2)
DEBOUNCE, 4, consecutive stable cycles required before filtered input changes (0 = filter bypassed)
TURNAROUND, 1, high-Z cycles inserted between oe rising and actual drive (0 allowed)
RESET_VAL, 0, reset value of every pad_in_o bit (1-bit)

Ports:
clk_i  input  1  clock; all state on rising edge
rst_i  input  1  asynchronous active-high reset
pad_out_i  input  NPADS  value to drive per channel
pad_oe_i  input  NPADS  requested output enable per channel
pad_io  inout  NPADS  physical pad
pad_in_o  output  NPADS  synchronised, debounced pad value
pad_rise_o  output  NPADS  1-cycle pulse when pad_in_o goes 0->1
pad_fall_o  output  NPADS  1-cycle pulse when pad_in_o goes 1->0
pad_driving_o  output  NPADS  1 while channel actively drives pad_io

Behaviour:
- Reset (async, any time):
  - all channels go to IDLE; pad_io = Z on all bits immediately;
  - pad_in_o = {NPADS{RESET_VAL}}; synchroniser flops = RESET_VAL;
  - rise/fall = 0; driving = 0; counters = 0.
- Channels are fully independent; no cross-channel interaction.
- Drive FSM per channel, states IDLE, TURN, DRIVE:
  - IDLE: pad Z. If oe=1 at the edge: go to TURN with cnt=0 when TURNAROUND>0, else go directly to DRIVE.
  - TURN: pad Z. cnt increments each cycle while oe=1. When cnt==TURNAROUND-1 and oe=1: go to DRIVE. oe=0: go to IDLE.
  - DRIVE: pad_io[i] = pad_out_i[i]. Data path is combinational; only the enable is registered. oe=0: go to IDLE.
  - Deassert is registered: pad goes Z at the first edge where oe=0 is sampled, i.e. at most 1 cycle after oe falls.
  - Drive starts TURNAROUND+1 edges after oe is first sampled high.
  - pad_driving_o = (state==DRIVE).
  - oe toggling faster than TURNAROUND restarts from IDLE; the pad is never driven.
- Input path:
  - pad_io is sampled through SYNC_STAGES flops, giving s.
  - Raw sampling continues while driving, so the bank reads back its own drive.
- Debounce (DEBOUNCE>0):
  - if s==pad_in_o: counter=0;
  - else counter increments; when counter==DEBOUNCE-1 and s still differs, pad_in_o <= s and counter=0.
  - Any return of s to pad_in_o before that clears the counter; glitches shorter than DEBOUNCE cycles are rejected.
  - Latency from a stable pad change to pad_in_o = SYNC_STAGES+DEBOUNCE edges.
- DEBOUNCE=0: pad_in_o <= s every cycle; latency SYNC_STAGES+1.
- Counter width: $clog2(max(DEBOUNCE,TURNAROUND)+1), min 1; counters saturate and never wrap.
- Edge pulses:
  - pad_rise_o / pad_fall_o are registered, asserted for exactly the cycle after pad_in_o changes.
  - Never both high on the same channel.

Optional Feature:
Macro PAD_BANK_LOOPBACK_EN.
- Defined: adds input port loopback_i [NPADS]. For a channel with loopback_i=1, the synchroniser input is taken from (state==DRIVE ? pad_out_i : RESET_VAL) instead of pad_io. The pad itself still follows the FSM. Used for pad-less self test.
- Undefined: port absent; synchroniser always samples pad_io.

Test Plan:
- Reset release, NPADS=8, no stimulus -> pad_io all Z, pad_in_o=8'h00, rise/fall/driving=0.
- TURNAROUND=1, oe[0] rises at edge 0, pad_out[0]=1 -> pad_io[0] Z at edges 0-1, driven 1 from edge 2; driving_o[0]=1 from edge 2; oe low at edge 10 -> Z after edge 11.
- DEBOUNCE=4, SYNC_STAGES=2, external pad[3] 0->1 held -> pad_in_o[3]=1 after 6 edges; pad_rise_o[3] high exactly 1 cycle after that.
- DEBOUNCE=4, 3-cycle high glitch on pad[5] -> pad_in_o[5] stays 0, no pulses.
- oe[2] toggled 1,0,1,0 each cycle with TURNAROUND=2 -> pad_io[2] never driven, driving_o[2]=0 throughout.
- rst_i asserted while channel 1 is in DRIVE -> pad_io[1] Z in the same cycle (async); pad_in_o reset; FSM restarts from IDLE after release.
